// File: rtl/uart_seq_pkg.sv
// Shared state encoding and command codes for the UART/SD FIFO sequencer.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_FILL  = 3'd1,
        ST_TX_DRAIN = 3'd2,
        ST_SD_INIT  = 3'd3,
        ST_SD_READ  = 3'd4,
        ST_DONE     = 3'd5
    } seq_state_e;

    localparam logic [7:0] CMD_SAF     = 8'h01;
    localparam logic [7:0] CMD_SD_INIT = 8'h02;
    localparam logic [7:0] CMD_SD_READ = 8'h03;
    localparam logic [7:0] CMD_CT      = 8'h04;

endpackage

// File: rtl/seq_sync_fifo.sv
// Show-ahead synchronous byte FIFO with flush; a push on a full FIFO is taken only alongside a pop.
module seq_sync_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_fifo_sequencer.sv
// Command-driven sequencer moving UART RX or SD read bytes through a FIFO to UART TX.
// Define SEQ_TIMEOUT_EN to add the TO_CYC watchdog and the sticky tmo output.
module uart_fifo_sequencer
    import uart_seq_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TO_CYC = 1000000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       cmd,
    input  logic             cmd_vld,
    input  logic [CNT_W-1:0] rx_cnt,
    input  logic [DW-1:0]    rx_data,
    input  logic             rx_vld,
    output logic [DW-1:0]    tx_data,
    output logic             tx_vld,
    input  logic             tx_rdy,
    output logic             sd_init,
    input  logic             init_ok,
    output logic             sd_ren,
    input  logic [DW-1:0]    sd_rdata,
    input  logic             sd_rvld,
    input  logic             sd_read_ok,
    output logic             busy,
    output logic             done,
    output logic             ovf,
`ifdef SEQ_TIMEOUT_EN
    output logic             cmd_err,
    output logic             tmo
`else
    output logic             cmd_err
`endif
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ct_q, ct_d;
    logic             ovf_q, ovf_d;
    logic             cmd_err_q, cmd_err_d;
    logic             ne_q;

    logic             accept_c;
    logic             wr_req_c;
    logic             push_c;
    logic             pop_c;
    logic             flush_c;
    logic             tx_vld_c;
    logic [DW-1:0]    wdata_c;

    logic [DW-1:0]    fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TO_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            tmo_q, tmo_d;
`endif

    seq_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_c),
        .push  (push_c),
        .wdata (wdata_c),
        .pop   (pop_c),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ct_d      = ct_q;
        ovf_d     = ovf_q;
        cmd_err_d = 1'b0;
        accept_c  = 1'b0;
        wr_req_c  = 1'b0;
        wdata_c   = rx_data;
        tx_vld_c  = 1'b0;
        flush_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    case (cmd)
                        CMD_SAF, CMD_CT: begin
                            accept_c = 1'b1;
                            cnt_d    = rx_cnt;
                            ct_d     = (cmd == CMD_CT);
                            state_d  = (rx_cnt == '0) ? ST_DONE : ST_RX_FILL;
                        end
                        CMD_SD_INIT: begin
                            accept_c = 1'b1;
                            state_d  = ST_SD_INIT;
                        end
                        CMD_SD_READ: begin
                            accept_c = 1'b1;
                            state_d  = ST_SD_READ;
                        end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            ST_RX_FILL: begin
                // Cut-through only forwards once the FIFO has been non-empty for a full cycle.
                tx_vld_c = ct_q & ~fifo_empty & ne_q;
                if (rx_vld) begin
                    wr_req_c = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_TX_DRAIN;
                    end
                end
            end
            ST_TX_DRAIN: begin
                tx_vld_c = ~fifo_empty;
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_SD_INIT: begin
                if (init_ok) begin
                    state_d = ST_DONE;
                end
            end
            ST_SD_READ: begin
                tx_vld_c = ~fifo_empty;
                wdata_c  = sd_rdata;
                wr_req_c = sd_rvld;
                if (sd_read_ok) begin
                    state_d = ST_TX_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            ovf_d = 1'b0;
        end

        // A write into a full FIFO survives only when a read frees a slot in the same cycle.
        pop_c  = tx_vld_c & tx_rdy;
        push_c = wr_req_c & (~fifo_full | pop_c);
        if (wr_req_c && fifo_full && !pop_c) begin
            ovf_d = 1'b1;
        end

`ifdef SEQ_TIMEOUT_EN
        tmo_d = accept_c ? 1'b0 : tmo_q;
        if (state_q != ST_IDLE && state_q != ST_DONE && wd_q == WD_W'(TO_CYC)) begin
            state_d = ST_DONE;
            flush_c = 1'b1;
            push_c  = 1'b0;
            tmo_d   = 1'b1;
        end
        if (state_q == ST_IDLE || state_d != state_q || rx_vld || sd_rvld || pop_c) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ct_q      <= 1'b0;
            ovf_q     <= 1'b0;
            cmd_err_q <= 1'b0;
            ne_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ct_q      <= ct_d;
            ovf_q     <= ovf_d;
            cmd_err_q <= cmd_err_d;
            ne_q      <= ~fifo_empty;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`endif

    assign tx_vld  = tx_vld_c;
    assign tx_data = tx_vld_c ? fifo_head : '0;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign sd_init = (state_q == ST_SD_INIT);
    assign sd_ren  = (state_q == ST_SD_READ);
    assign ovf     = ovf_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_uart_fifo_sequencer.sv
// Self-checking bench for uart_fifo_sequencer: command table, directed corner cases, randomized transfers.
module tb_uart_fifo_sequencer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;
`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TO_CYC = 40;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       cmd;
    logic             cmd_vld;
    logic [CNT_W-1:0] rx_cnt;
    logic [DW-1:0]    rx_data;
    logic             rx_vld;
    logic [DW-1:0]    tx_data;
    logic             tx_vld;
    logic             tx_rdy;
    logic             sd_init;
    logic             init_ok;
    logic             sd_ren;
    logic [DW-1:0]    sd_rdata;
    logic             sd_rvld;
    logic             sd_read_ok;
    logic             busy;
    logic             done;
    logic             ovf;
    logic             cmd_err;
`ifdef SEQ_TIMEOUT_EN
    logic             tmo;
`endif

    uart_fifo_sequencer #(
        .DW     (DW),
        .DEPTH  (DEPTH),
`ifdef SEQ_TIMEOUT_EN
        .TO_CYC (TO_CYC),
`endif
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_vld    (cmd_vld),
        .rx_cnt     (rx_cnt),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .tx_data    (tx_data),
        .tx_vld     (tx_vld),
        .tx_rdy     (tx_rdy),
        .sd_init    (sd_init),
        .init_ok    (init_ok),
        .sd_ren     (sd_ren),
        .sd_rdata   (sd_rdata),
        .sd_rvld    (sd_rvld),
        .sd_read_ok (sd_read_ok),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf),
`ifdef SEQ_TIMEOUT_EN
        .tmo        (tmo),
`endif
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_at  = -1;
    int first_rx = -1;
    int first_tx = -1;
    bit rand_rdy = 1'b0;
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];

    typedef struct packed {
        logic [7:0]  c;
        logic [15:0] n;
        logic        err;
        logic        bsy;
        logic        dn;
        logic        sdi;
        logic        sdr;
    } vec_t;
    localparam int NV = 9;
    vec_t vt[NV];

    always @(posedge clk) cyc++;

    // Observe the TX handshake and status pulses half a cycle away from the active edge.
    always @(negedge clk) begin
        if (tx_vld && tx_rdy) got.push_back(tx_data);
        if (done) begin
            done_cnt++;
            done_at = got.size();
        end
        if (cmd_err) err_cnt++;
        if (rx_vld && first_rx < 0) first_rx = cyc;
        if (tx_vld && first_tx < 0) first_tx = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) tx_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endtask

    task automatic clear_mon();
        got.delete();
        exp_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        done_at  = -1;
        first_rx = -1;
        first_tx = -1;
    endtask

    task automatic send_cmd(input logic [7:0] c, input int n);
        cmd     = c;
        rx_cnt  = CNT_W'(n);
        cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        cmd     = 8'h00;
    endtask

    task automatic send_rx(input int d);
        rx_data = DW'(d);
        rx_vld  = 1'b1;
        step();
        rx_vld  = 1'b0;
    endtask

    task automatic send_sd(input int d, input bit last);
        sd_rdata   = DW'(d);
        sd_rvld    = 1'b1;
        sd_read_ok = last;
        step();
        sd_rvld    = 1'b0;
        sd_read_ok = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_stream(input string nm);
        chk({nm, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    // Push every possible pending operation to completion.
    task automatic drain_all();
        int n = 0;
        init_ok    = 1'b1;
        sd_read_ok = 1'b1;
        rx_vld     = 1'b1;
        rx_data    = 8'h5A;
        tx_rdy     = 1'b1;
        while (busy && n < 60) begin
            step();
            n++;
        end
        init_ok    = 1'b0;
        sd_read_ok = 1'b0;
        rx_vld     = 1'b0;
        chk("cleanup_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cmd = 8'h00; cmd_vld = 1'b0; rx_cnt = '0; rx_data = '0; rx_vld = 1'b0;
        tx_rdy = 1'b0; init_ok = 1'b0; sd_rdata = '0; sd_rvld = 1'b0; sd_read_ok = 1'b0;

        //          cmd    cnt    err  bsy  dn   sdi  sdr
        vt[0] = '{8'h07, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{8'h00, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{8'hFF, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{8'h05, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{8'h01, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'h04, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[6] = '{8'h02, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[7] = '{8'h03, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[8] = '{8'h01, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (3) step();
        chk("rst_tx_vld",  32'(tx_vld),  32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_ovf",     32'(ovf),     32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("rst_sd_init", 32'(sd_init), 32'd0);
        chk("rst_sd_ren",  32'(sd_ren),  32'd0);
        rst_n = 1'b1;
        step();

        // Command decode table: outputs one cycle after the strobe.
        for (int i = 0; i < NV; i++) begin
            clear_mon();
            send_cmd(vt[i].c, int'(vt[i].n));
            chk($sformatf("vec%0d_cmd_err", i), 32'(cmd_err), 32'(vt[i].err));
            chk($sformatf("vec%0d_busy", i),    32'(busy),    32'(vt[i].bsy));
            chk($sformatf("vec%0d_done", i),    32'(done),    32'(vt[i].dn));
            chk($sformatf("vec%0d_sd_init", i), 32'(sd_init), 32'(vt[i].sdi));
            chk($sformatf("vec%0d_sd_ren", i),  32'(sd_ren),  32'(vt[i].sdr));
            drain_all();
        end

        // Store-and-forward, 5 bytes.
        clear_mon();
        tx_rdy = 1'b1;
        send_cmd(8'h01, 5);
        for (int i = 0; i < 5; i++) begin
            chk("saf5_txvld_fill", 32'(tx_vld), 32'd0);
            send_rx(8'h11 + i);
            exp_q.push_back(8'(8'h11 + i));
        end
        wait_idle("saf5", 100);
        chk_stream("saf5");
        chk("saf5_done_cnt", 32'(done_cnt), 32'd1);
        chk("saf5_ovf", 32'(ovf), 32'd0);

        // Cut-through, 40 bytes, one every 4 cycles.
        clear_mon();
        send_cmd(8'h04, 40);
        for (int i = 0; i < 40; i++) begin
            send_rx(i * 7 + 3);
            exp_q.push_back(8'(i * 7 + 3));
            repeat (3) step();
        end
        wait_idle("ct40", 100);
        chk_stream("ct40");
        chk("ct40_ovf", 32'(ovf), 32'd0);
        chk("ct40_done_cnt", 32'(done_cnt), 32'd1);
        chk("ct40_latency_ge2", 32'(first_tx - first_rx >= 2), 32'd1);

        // Store-and-forward overflow: 20 bytes into 16 slots.
        clear_mon();
        send_cmd(8'h01, 20);
        for (int i = 0; i < 20; i++) begin
            send_rx(8'h40 + i);
            if (i < DEPTH) exp_q.push_back(8'(8'h40 + i));
        end
        wait_idle("saf20", 100);
        chk_stream("saf20");
        chk("saf20_ovf", 32'(ovf), 32'd1);
        chk("saf20_done_cnt", 32'(done_cnt), 32'd1);
        send_cmd(8'h01, 0);
        chk("saf20_ovf_cleared", 32'(ovf), 32'd0);
        wait_idle("ovf_clear", 10);

        // SD read, 8 bytes, TX ready toggling.
        clear_mon();
        rand_rdy = 1'b1;
        send_cmd(8'h03, 0);
        chk("sd8_ren_on", 32'(sd_ren), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            if (i == 7) chk("sd8_ren_before_ok", 32'(sd_ren), 32'd1);
            send_sd(8'hC0 + i, i == 7);
            exp_q.push_back(8'(8'hC0 + i));
        end
        chk("sd8_ren_fall", 32'(sd_ren), 32'd0);
        wait_idle("sd8", 300);
        rand_rdy = 1'b0;
        tx_rdy   = 1'b1;
        chk_stream("sd8");
        chk("sd8_done_cnt", 32'(done_cnt), 32'd1);
        chk("sd8_done_after_last", 32'(done_at), 32'd8);

        // A command during RX_FILL must be ignored.
        clear_mon();
        send_cmd(8'h01, 2);
        send_rx(8'hA1);
        send_cmd(8'h01, 7);
        chk("ignore_busy", 32'(busy), 32'd1);
        send_rx(8'hA2);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        wait_idle("ignore", 50);
        chk_stream("ignore");
        chk("ignore_err_cnt", 32'(err_cnt), 32'd0);
        chk("ignore_done_cnt", 32'(done_cnt), 32'd1);

        // Reset in TX_DRAIN with 3 bytes queued.
        clear_mon();
        tx_rdy = 1'b0;
        send_cmd(8'h01, 3);
        for (int i = 0; i < 3; i++) send_rx(8'h70 + i);
        chk("rstmid_pre_tx_vld", 32'(tx_vld), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rstmid_tx_vld",  32'(tx_vld),  32'd0);
        chk("rstmid_tx_data", 32'(tx_data), 32'd0);
        chk("rstmid_busy",    32'(busy),    32'd0);
        chk("rstmid_done",    32'(done),    32'd0);
        chk("rstmid_ovf",     32'(ovf),     32'd0);
        rst_n  = 1'b1;
        tx_rdy = 1'b1;
        repeat (4) step();
        chk("rstmid_no_done", 32'(done_cnt), 32'd0);
        chk("rstmid_no_tx", 32'(got.size()), 32'd0);
        send_cmd(8'h01, 1);
        send_rx(8'hAB);
        exp_q.push_back(8'hAB);
        wait_idle("rstmid_after", 50);
        chk_stream("rstmid_after");

        // Randomized transfers against a byte-stream reference model.
        for (int it = 0; it < 12; it++) begin
            int mode;
            int n;
            clear_mon();
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                n = int'($urandom_range(0, 24));
                rand_rdy = 1'b1;
                send_cmd(8'h01, n);
                for (int i = 0; i < n; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    if (i < DEPTH) exp_q.push_back(b);
                    send_rx(int'(b));
                    repeat ($urandom_range(0, 2)) step();
                end
            end else if (mode == 1) begin
                n = int'($urandom_range(1, 40));
                rand_rdy = 1'b0;
                tx_rdy   = 1'b1;
                send_cmd(8'h04, n);
                for (int i = 0; i < n; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    send_rx(int'(b));
                    repeat ($urandom_range(0, 3)) step();
                end
            end else begin
                n = int'($urandom_range(1, DEPTH));
                rand_rdy = 1'b1;
                send_cmd(8'h03, 0);
                for (int i = 0; i < n; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    repeat ($urandom_range(0, 2)) step();
                    send_sd(int'(b), i == n - 1);
                end
            end
            wait_idle($sformatf("rnd%0d", it), 500);
            rand_rdy = 1'b0;
            tx_rdy   = 1'b1;
            chk_stream($sformatf("rnd%0d_m%0d", it, mode));
            chk($sformatf("rnd%0d_ovf", it), 32'(ovf), 32'(mode == 0 && n > int'(DEPTH)));
            chk($sformatf("rnd%0d_done_cnt", it), 32'(done_cnt), 32'd1);
        end

`ifdef SEQ_TIMEOUT_EN
        // SD init that never completes must time out.
        begin
            int n = 0;
            clear_mon();
            send_cmd(8'h02, 0);
            while (!done && n < 4 * int'(TO_CYC)) begin
                step();
                n++;
            end
            chk("tmo_latency", 32'(n), 32'(TO_CYC + 1));
            chk("tmo_flag", 32'(tmo), 32'd1);
            chk("tmo_sd_init_drop", 32'(sd_init), 32'd0);
            step();
            chk("tmo_idle", 32'(busy), 32'd0);
            chk("tmo_sticky", 32'(tmo), 32'd1);
            send_cmd(8'h01, 0);
            chk("tmo_cleared", 32'(tmo), 32'd0);
            wait_idle("tmo_after", 10);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo_sequencer.md
Name: uart_fifo_sequencer

Overview:
- Command-driven sequencer between the UART receiver/transmitter, an internal byte FIFO and the SD-card front end.
- Moves a programmable number of received bytes into the FIFO and drains them to the UART TX, in store-and-forward or cut-through mode.
- Sequences SD init and SD block read, streaming SD read data through the same FIFO to TX.
- Parametrised successor of the fixed 8-bit, single-mode UART FIFO controller; sits between the command decoder and the uart_rx/uart_tx/sd_ctrl blocks.

Parameters:
DW, 8, data width of RX/TX/SD bytes
DEPTH, 16, FIFO depth in words; power of two, minimum 2
CNT_W, 16, width of the transfer byte counter
TO_CYC, 1000000, watchdog limit in clk cycles (only with SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  synchronous active-low reset
cmd  in  8  command code; sampled in IDLE when cmd_vld=1
cmd_vld  in  1  command strobe, one cycle
rx_cnt  in  CNT_W  byte count, latched with cmd 0x01/0x04
rx_data  in  DW  byte from UART receiver
rx_vld  in  1  one-cycle strobe per received byte
tx_data  out  DW  FIFO head byte to UART TX
tx_vld  out  1  tx_data valid
tx_rdy  in  1  UART TX can accept a byte
sd_init  out  1  SD init request, level
init_ok  in  1  SD init complete
sd_ren  out  1  SD read request, level
sd_rdata  in  DW  SD read byte
sd_rvld  in  1  SD read byte strobe
sd_read_ok  in  1  SD read complete
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on entry to DONE
ovf  out  1  sticky overflow flag; cleared by next accepted command or reset
cmd_err  out  1  one-cycle pulse on unknown command in IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, FIFO flushed, counter=0; all outputs 0. Mid-operation reset aborts the transfer immediately; no done pulse.
- Commands (accepted only in IDLE with cmd_vld=1; ignored in any other state):
  - 0x01: store-and-forward (SAF).
  - 0x02: SD init.
  - 0x03: SD read.
  - 0x04: cut-through (CT).
  - Any other code: cmd_err pulse, remain in IDLE.
  - An accepted command clears ovf.
- States: IDLE, RX_FILL, TX_DRAIN, SD_INIT, SD_READ, DONE.
- 0x01/0x04: latch cnt=rx_cnt. If rx_cnt=0, go to DONE next cycle. Otherwise go to RX_FILL.
- RX_FILL:
  - Each rx_vld decrements cnt and writes rx_data to the FIFO.
  - FIFO full while rx_vld: byte dropped, ovf=1, cnt still decrements.
  - SAF: tx_vld=0 throughout.
  - CT: tx_vld=!empty; reads occur concurrently. A simultaneous read and write on a full FIFO is accepted, not an overflow.
  - When cnt reaches 0, go to TX_DRAIN.
- TX_DRAIN:
  - tx_vld=!empty; tx_data=FIFO head (show-ahead, zero read latency).
  - A pop happens on tx_vld & tx_rdy.
  - Go to DONE in the cycle after the FIFO becomes empty.
- SD_INIT: sd_init=1 from the cycle after acceptance. On init_ok: sd_init=0, go to DONE.
- SD_READ:
  - sd_ren=1. sd_rvld writes sd_rdata to the FIFO, with the same overflow rule as RX_FILL.
  - TX drains concurrently.
  - On sd_read_ok: sd_ren=0, go to TX_DRAIN. If sd_rvld and sd_read_ok coincide, the final byte is written.
- DONE: lasts one cycle, done=1, then IDLE.
- rx_vld outside RX_FILL is ignored, with no ovf. sd_rvld outside SD_READ is ignored.
- Counter arithmetic: CNT_W bits, no wrap; decrements only while nonzero.
- Latency: command to first tx_vld in CT mode is at least 2 cycles after the first rx_vld.

Optional Feature:
SEQ_TIMEOUT_EN:
- Defined: a watchdog counter resets on every state change and on every rx_vld, sd_rvld or TX pop.
- When it reaches TO_CYC in any non-IDLE state:
  - Force DONE.
  - Drop sd_init/sd_ren.
  - Flush the FIFO.
  - Raise output port tmo (1 bit, sticky, cleared like ovf).
- Undefined: no watchdog and no tmo port; the block can wait indefinitely.

Decomposition:
- Package uart_seq_pkg holds:
  - The state encoding.
  - Command codes CMD_SAF=8'h01, CMD_SD_INIT=8'h02, CMD_SD_READ=8'h03, CMD_CT=8'h04.
- One sub-module, seq_sync_fifo:
  - Parameters DW and DEPTH; show-ahead output.
  - Signals: full, empty, push, pop, flush.
  - Synchronous active-low reset.

Test Plan:
- SAF, rx_cnt=5, bytes 0x11..0x15, tx_rdy=1: tx_vld stays 0 until the 5th byte, then 0x11..0x15 in order, one done pulse, busy returns to 0.
- CT, rx_cnt=40, DEPTH=16, tx_rdy=1 with 1 byte every 4 cycles: all 40 bytes out in order, ovf=0.
- SAF, rx_cnt=20, DEPTH=16: bytes 17..20 dropped, ovf=1, exactly 16 bytes transmitted, done pulse; next cmd 0x01 clears ovf.
- cmd 0x03 with 8 sd_rvld bytes, sd_read_ok on the 8th, tx_rdy toggling: 8 bytes out, sd_ren falls the cycle after sd_read_ok, done after last pop.
- cmd 0x07 in IDLE -> cmd_err pulse, state stays IDLE; cmd 0x01 issued during RX_FILL -> ignored.
- rst_n=0 mid-TX_DRAIN with 3 bytes queued -> next cycle all outputs 0, FIFO empty, no done; with SEQ_TIMEOUT_EN, cmd 0x02 with init_ok never asserted -> tmo=1 and DONE after TO_CYC cycles.
